// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions: hazard-controller state encoding and
// operand-forwarding select codes.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MUL_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Width of the multicycle-wait and flush counters (MulLatency up to 15)
  localparam int CntBits = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Operand forwarding select for one source operand. EX result beats MEM result;
// loads in EX cannot forward (their data is not ready yet). Index 0 never forwards.
module pipeline_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NrOfRegBits = 5
) (
  input  logic [NrOfRegBits-1:0] i_rs,
  input  logic [NrOfRegBits-1:0] i_ex_rd,
  input  logic                   i_ex_reg_write,
  input  logic                   i_ex_mem_read,
  input  logic [NrOfRegBits-1:0] i_mem_rd,
  input  logic                   i_mem_reg_write,
  output logic [1:0]             o_sel
);

  logic [1:0] w_sel;

  // Priority select of the newest available producer of i_rs
  always_comb begin
    w_sel = FWD_RF;
    if (i_rs == {NrOfRegBits{1'b0}}) begin
      w_sel = FWD_RF;
    end else if (i_ex_reg_write && !i_ex_mem_read && (i_ex_rd == i_rs)) begin
      w_sel = FWD_EX;
    end else if (i_mem_reg_write && (i_mem_rd == i_rs)) begin
      w_sel = FWD_MEM;
    end else begin
      w_sel = FWD_RF;
    end
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multicycle hold in ID, branch flush,
// operand forwarding selects and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NrOfRegBits = 5,
  parameter int MulLatency  = 4,
  parameter int FlushCycles = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic [NrOfRegBits-1:0] ID_Rs1,
  input  logic [NrOfRegBits-1:0] ID_Rs2,
  input  logic                   ID_MulDiv,
  input  logic [NrOfRegBits-1:0] EX_Rd,
  input  logic                   EX_RegWrite,
  input  logic                   EX_MemRead,
  input  logic [NrOfRegBits-1:0] MEM_Rd,
  input  logic                   MEM_RegWrite,
  input  logic                   BranchTaken,
  output logic                   PC_En,
  output logic                   IFID_En,
  output logic                   IDEX_En,
  output logic                   IFID_Flush,
  output logic                   IDEX_Flush,
  output logic [1:0]             FwdA,
  output logic [1:0]             FwdB,
  output logic                   Busy,
  output logic [15:0]            StallCount
);

  // The RUN entry cycle already holds ID, so MUL_WAIT covers the remaining
  // MulLatency-1 hold cycles; FLUSH lasts FlushCycles Tick cycles.
  localparam logic [CntBits-1:0] MulInit   = CntBits'(MulLatency - 1);
  localparam logic [CntBits-1:0] FlushInit = CntBits'(FlushCycles - 1);

  hz_state_e          r_state;
  logic [CntBits-1:0] r_wait_cnt;
  logic [CntBits-1:0] r_flush_cnt;
  logic               r_mul_done;
  logic [15:0]        r_stall_cnt;

  logic w_load_use;
  logic w_pc_en, w_ifid_en, w_idex_en, w_ifid_flush, w_idex_flush;

  pipeline_fwd_unit #(.NrOfRegBits(NrOfRegBits)) u_fwd_a (
    .i_rs(ID_Rs1), .i_ex_rd(EX_Rd), .i_ex_reg_write(EX_RegWrite),
    .i_ex_mem_read(EX_MemRead), .i_mem_rd(MEM_Rd), .i_mem_reg_write(MEM_RegWrite),
    .o_sel(FwdA)
  );

  pipeline_fwd_unit #(.NrOfRegBits(NrOfRegBits)) u_fwd_b (
    .i_rs(ID_Rs2), .i_ex_rd(EX_Rd), .i_ex_reg_write(EX_RegWrite),
    .i_ex_mem_read(EX_MemRead), .i_mem_rd(MEM_Rd), .i_mem_reg_write(MEM_RegWrite),
    .o_sel(FwdB)
  );

  assign w_load_use = EX_MemRead && (EX_Rd != {NrOfRegBits{1'b0}}) &&
                      ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2));

  // Enable/flush decode of the current state and this cycle's hazard events
  always_comb begin
    w_pc_en      = 1'b0;
    w_ifid_en    = 1'b0;
    w_idex_en    = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    if (Tick) begin
      case (r_state)
        ST_RUN: begin
          if (BranchTaken) begin
            {w_pc_en, w_ifid_en, w_idex_en} = 3'b111;
            {w_ifid_flush, w_idex_flush}    = 2'b11;
          end else if (w_load_use) begin
            w_idex_en    = 1'b1;
            w_idex_flush = 1'b1;
          end else if (ID_MulDiv && !r_mul_done) begin
            {w_pc_en, w_ifid_en, w_idex_en} = 3'b000;
          end else begin
            {w_pc_en, w_ifid_en, w_idex_en} = 3'b111;
          end
        end
        ST_MUL_WAIT: begin
          if (BranchTaken) begin
            {w_pc_en, w_ifid_en, w_idex_en} = 3'b111;
            {w_ifid_flush, w_idex_flush}    = 2'b11;
          end else begin
            {w_pc_en, w_ifid_en, w_idex_en} = 3'b000;
          end
        end
        ST_FLUSH: begin
          {w_pc_en, w_ifid_en, w_idex_en} = 3'b111;
          {w_ifid_flush, w_idex_flush}    = 2'b11;
        end
        default: begin
          {w_pc_en, w_ifid_en, w_idex_en} = 3'b000;
        end
      endcase
    end else begin
      {w_pc_en, w_ifid_en, w_idex_en} = 3'b000;
    end
  end

  // Controller state, hold/flush counters and the one-shot multicycle release flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= {CntBits{1'b0}};
      r_flush_cnt <= {CntBits{1'b0}};
      r_mul_done  <= 1'b0;
    end else if (Tick) begin
      case (r_state)
        ST_RUN: begin
          r_mul_done <= 1'b0;
          if (BranchTaken) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FlushInit;
          end else if (!w_load_use && ID_MulDiv && !r_mul_done) begin
            r_state    <= ST_MUL_WAIT;
            r_wait_cnt <= MulInit;
          end
        end
        ST_MUL_WAIT: begin
          if (BranchTaken) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FlushInit;
            r_wait_cnt  <= {CntBits{1'b0}};
            r_mul_done  <= 1'b0;
          end else if (r_wait_cnt <= 4'd1) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= {CntBits{1'b0}};
            r_mul_done <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating count of Tick cycles in which the PC was held
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_stall_cnt <= 16'd0;
    end else if (Tick && !w_pc_en && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign PC_En      = w_pc_en;
  assign IFID_En    = w_ifid_en;
  assign IDEX_En    = w_idex_en;
  assign IFID_Flush = w_ifid_flush;
  assign IDEX_Flush = w_idex_flush;
  assign Busy       = (r_state != ST_RUN);
  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle-level behavioural model
// compared every cycle, plus literal checks of the directed scenarios.
module tb_pipeline_hazard_ctrl;

  localparam int RB = 5;
  localparam int ML = 4;
  localparam int FC = 1;

  logic          Clock = 1'b0;
  logic          Reset, Tick, ID_MulDiv, EX_RegWrite, EX_MemRead, MEM_RegWrite, BranchTaken;
  logic [RB-1:0] ID_Rs1, ID_Rs2, EX_Rd, MEM_Rd;
  logic          PC_En, IFID_En, IDEX_En, IFID_Flush, IDEX_Flush, Busy;
  logic [1:0]    FwdA, FwdB;
  logic [15:0]   StallCount;

  int n_cmp = 0;
  int n_bad = 0;
  int s0;

  // Model state: remaining multicycle hold cycles, remaining flush cycles,
  // "multicycle op may advance once" flag, and stall tally.
  int m_hold, m_flush, m_stalls;
  bit m_pass;

  pipeline_hazard_ctrl #(.NrOfRegBits(RB), .MulLatency(ML), .FlushCycles(FC)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
    .ID_MulDiv(ID_MulDiv), .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .BranchTaken(BranchTaken),
    .PC_En(PC_En), .IFID_En(IFID_En), .IDEX_En(IDEX_En), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .FwdA(FwdA), .FwdB(FwdB), .Busy(Busy), .StallCount(StallCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lu_now();
    return EX_MemRead && (EX_Rd != 0) && (EX_Rd == ID_Rs1 || EX_Rd == ID_Rs2);
  endfunction

  // Expected {PC_En, IFID_En, IDEX_En, IFID_Flush, IDEX_Flush}
  function automatic logic [4:0] exp_ctl();
    if (!Tick)                    return 5'b00000;
    if (m_flush > 0)              return 5'b11111;
    if (m_hold > 0)               return BranchTaken ? 5'b11111 : 5'b00000;
    if (BranchTaken)              return 5'b11111;
    if (lu_now())                 return 5'b00101;
    if (ID_MulDiv && !m_pass)     return 5'b00000;
    return 5'b11100;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [RB-1:0] rs);
    if (rs == 0) return 2'b00;
    if (EX_RegWrite && !EX_MemRead && EX_Rd == rs) return 2'b01;
    if (MEM_RegWrite && MEM_Rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Model advance on each Tick cycle
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_hold <= 0; m_flush <= 0; m_pass <= 1'b0; m_stalls <= 0;
    end else if (Tick) begin
      if (!exp_ctl()[4] && m_stalls < 65535) m_stalls <= m_stalls + 1;
      if (m_flush > 0) begin
        m_flush <= m_flush - 1;
      end else if (m_hold > 0) begin
        if (BranchTaken) begin
          m_hold <= 0; m_flush <= FC; m_pass <= 1'b0;
        end else begin
          m_hold <= m_hold - 1;
          m_pass <= (m_hold == 1);
        end
      end else begin
        m_pass <= 1'b0;
        if (BranchTaken) m_flush <= FC;
        else if (!lu_now() && ID_MulDiv && !m_pass) m_hold <= ML - 1;
      end
    end
  end

  // Every-cycle comparison of DUT against the model
  always @(negedge Clock) begin
    logic [4:0] e;
    e = exp_ctl();
    check("PC_En", PC_En, e[4]);
    check("IFID_En", IFID_En, e[3]);
    check("IDEX_En", IDEX_En, e[2]);
    check("IFID_Flush", IFID_Flush, e[1]);
    check("IDEX_Flush", IDEX_Flush, e[0]);
    check("Busy", Busy, (m_flush > 0) || (m_hold > 0));
    check("StallCount", StallCount, m_stalls);
    check("FwdA", FwdA, exp_fwd(ID_Rs1));
    check("FwdB", FwdB, exp_fwd(ID_Rs2));
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic quiet();
    ID_Rs1 = 5'd1; ID_Rs2 = 5'd2; ID_MulDiv = 1'b0; EX_Rd = 5'd0; EX_RegWrite = 1'b0;
    EX_MemRead = 1'b0; MEM_Rd = 5'd0; MEM_RegWrite = 1'b0; BranchTaken = 1'b0; Tick = 1'b1;
  endtask

  initial begin
    Reset = 1'b1;
    quiet();
    step(2);
    check("rst_busy", Busy, 1'b0);
    check("rst_stall", StallCount, 16'd0);
    Reset = 1'b0;

    // Forwarding selects, Tick low so no state moves
    Tick = 1'b0;
    EX_RegWrite = 1'b1; EX_Rd = 5'd5; ID_Rs1 = 5'd5; MEM_Rd = 5'd5; MEM_RegWrite = 1'b1;
    #2 check("fwd_ex", FwdA, 2'b01);
    EX_Rd = 5'd0;
    #2 check("fwd_mem", FwdA, 2'b10);
    ID_Rs1 = 5'd0;
    #2 check("fwd_r0", FwdA, 2'b00);
    EX_Rd = 5'd7; ID_Rs2 = 5'd7; EX_MemRead = 1'b1; MEM_Rd = 5'd9;
    #2 check("fwd_load_excluded", FwdB, 2'b00);
    #2 check("tick0_pc", PC_En, 1'b0);
    step(1);
    quiet();
    step(3);

    // Load-use stall
    EX_MemRead = 1'b1; EX_Rd = 5'd3; ID_Rs2 = 5'd3;
    #2 check("lu_pc", PC_En, 1'b0);
    check("lu_idex_flush", IDEX_Flush, 1'b1);
    step(1);
    quiet();
    check("lu_stall", StallCount, 16'd1);
    step(2);

    // Multicycle hold: 4 stall cycles, then one advance
    s0 = StallCount;
    ID_MulDiv = 1'b1;
    step(4);
    #2 check("mul_adv_pc", PC_En, 1'b1);
    check("mul_adv_busy", Busy, 1'b0);
    step(1);
    ID_MulDiv = 1'b0;
    check("mul_stalls", StallCount, 16'(s0 + 4));
    step(2);

    // Branch in second MUL_WAIT cycle aborts the wait
    ID_MulDiv = 1'b1;
    step(2);
    BranchTaken = 1'b1; ID_MulDiv = 1'b0;
    #2 check("br_wait_flush", IFID_Flush, 1'b1);
    step(1);
    BranchTaken = 1'b0;
    check("br_flush_busy", Busy, 1'b1);
    step(1);
    check("br_run_busy", Busy, 1'b0);
    check("br_run_pc", PC_En, 1'b1);
    step(2);

    // Tick gap inside MUL_WAIT stretches the wait by one clock
    ID_MulDiv = 1'b1;
    step(2);
    Tick = 1'b0;
    step(1);
    Tick = 1'b1;
    step(1);
    check("gap_busy", Busy, 1'b1);
    step(1);
    check("gap_done", Busy, 1'b0);
    step(1);
    ID_MulDiv = 1'b0;
    step(2);

    // Mixed traffic against the model
    for (int i = 0; i < 80; i++) begin
      Tick         = ($urandom_range(0, 3) != 0);
      ID_Rs1       = RB'($urandom_range(0, 7));
      ID_Rs2       = RB'($urandom_range(0, 7));
      EX_Rd        = RB'($urandom_range(0, 7));
      MEM_Rd       = RB'($urandom_range(0, 7));
      EX_RegWrite  = $urandom_range(0, 1) != 0;
      EX_MemRead   = $urandom_range(0, 4) == 0;
      MEM_RegWrite = $urandom_range(0, 1) != 0;
      ID_MulDiv    = $urandom_range(0, 5) == 0;
      BranchTaken  = $urandom_range(0, 9) == 0;
      step(1);
    end
    quiet();
    step(6);

    // Reset in the middle of FLUSH
    BranchTaken = 1'b1;
    step(1);
    BranchTaken = 1'b0;
    check("pre_rst_busy", Busy, 1'b1);
    #2 Reset = 1'b1;
    #1 check("midrst_busy", Busy, 1'b0);
    check("midrst_stall", StallCount, 16'd0);
    step(1);
    Reset = 1'b0;
    #2 check("post_rst_en", {PC_En, IFID_En, IDEX_En}, 3'b111);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
